// File: rtl/iob_bpack.sv
// iob_bpack: packs variable-width, MSB-aligned fields into DATA_W-bit words.
// Bits are buffered MSB-first in a 2*DATA_W register; the top DATA_W bits
// form the output word. A flush zero-pads the partial tail word and marks
// the final word with olast_o.
module iob_bpack #(
  parameter int DATA_W = 21
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          rst_n_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  input  logic [$clog2(DATA_W):0]       wwidth_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          flush_i,
  output logic                          ovalid_o,
  input  logic                          oready_i,
  output logic [DATA_W-1:0]             odata_o,
  output logic                          olast_o,
  output logic [$clog2(2*DATA_W):0]     level_o
);

  localparam int WW = $clog2(DATA_W) + 1;
  localparam int LW = $clog2(2*DATA_W) + 1;
  localparam int BW = 2 * DATA_W;

  localparam logic [WW-1:0] DW_W = WW'(DATA_W);
  localparam logic [LW-1:0] DW_L = LW'(DATA_W);

  logic [BW-1:0]     bits_q, bits_d;
  logic [LW-1:0]     level_q, level_d;
  logic              flush_pend_q, flush_pend_d;

  logic [WW-1:0]     wwidth_c;
  logic [DATA_W-1:0] field_mask;
  logic [DATA_W-1:0] field;
  logic              w_acc;
  logic              o_acc;

  // Handshake outputs and the visible word, all derived from registered state.
  always_comb begin
    wready_o = rst_n_i & cke_i & (level_q <= DW_L) & ~flush_pend_q;
    ovalid_o = rst_n_i & cke_i &
               ((level_q >= DW_L) | (flush_pend_q & (level_q != '0)));
    olast_o  = ovalid_o & flush_pend_q & (level_q <= DW_L);
    odata_o  = bits_q[BW-1 -: DATA_W];
    level_o  = level_q;
    w_acc    = wvalid_i & wready_o;
    o_acc    = ovalid_o & oready_i;
  end

  // Clamp the width and keep only the top wwidth bits of the field, so the
  // buffer stays zero below the valid level.
  always_comb begin
    wwidth_c   = (wwidth_i > DW_W) ? DW_W : wwidth_i;
    field_mask = ~({DATA_W{1'b1}} >> wwidth_c);
    field      = wdata_i & field_mask;
  end

  // Next state: drain the head word first, then append the new field right
  // below whatever remains, so a simultaneous write at level DATA_W lands at
  // the MSB.
  always_comb begin
    logic [BW-1:0] bits_s;
    logic [LW-1:0] level_s;
    logic [BW-1:0] field_ext;

    bits_s  = bits_q;
    level_s = level_q;
    if (o_acc) begin
      bits_s  = bits_q << DATA_W;
      level_s = (level_q >= DW_L) ? (level_q - DW_L) : '0;
    end

    field_ext = {field, {DATA_W{1'b0}}} >> level_s;

    bits_d  = bits_s;
    level_d = level_s;
    if (w_acc) begin
      bits_d  = bits_s | field_ext;
      level_d = level_s + LW'(wwidth_c);
    end

    // A flush stays pending until the buffer has fully drained; a flush on an
    // empty buffer with no write therefore never becomes pending.
    flush_pend_d = (flush_pend_q | flush_i) & (level_d != '0);
  end

  // State registers: synchronous reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bits_q       <= '0;
      level_q      <= '0;
      flush_pend_q <= 1'b0;
    end else if (cke_i) begin
      bits_q       <= bits_d;
      level_q      <= level_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_iob_bpack.sv
// Directed bench for iob_bpack at DATA_W=8. Expected output words are pushed
// to a scoreboard as stimulus is issued; a monitor pops and compares every
// word the DUT hands over.
module tb_iob_bpack;

  localparam int DW = 8;

  logic       clk_i = 1'b0;
  logic       cke_i;
  logic       rst_n_i;
  logic       wvalid_i;
  logic       wready_o;
  logic [3:0] wwidth_i;
  logic [7:0] wdata_i;
  logic       flush_i;
  logic       ovalid_o;
  logic       oready_i;
  logic [7:0] odata_o;
  logic       olast_o;
  logic [4:0] level_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q[$];   // {last, data}

  iob_bpack #(.DATA_W(DW)) dut (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_n_i (rst_n_i),
    .wvalid_i(wvalid_i),
    .wready_o(wready_o),
    .wwidth_i(wwidth_i),
    .wdata_i (wdata_i),
    .flush_i (flush_i),
    .ovalid_o(ovalid_o),
    .oready_i(oready_i),
    .odata_o (odata_o),
    .olast_o (olast_o),
    .level_o (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] w, input logic [7:0] d, input logic fl);
    chk("wready_before_write", {31'd0, wready_o}, 32'd1);
    wvalid_i = 1'b1;
    wwidth_i = w;
    wdata_i  = d;
    flush_i  = fl;
    tick();
    wvalid_i = 1'b0;
    flush_i  = 1'b0;
  endtask

  // Monitor: every handshaken word must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (ovalid_o && oready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h expected none", odata_o);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("word_data", {24'd0, odata_o}, {24'd0, e[7:0]});
        chk("word_last", {31'd0, olast_o}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cke_i    = 1'b1;
    rst_n_i  = 1'b0;
    wvalid_i = 1'b1;
    wwidth_i = 4'd8;
    wdata_i  = 8'hAA;
    flush_i  = 1'b0;
    oready_i = 1'b0;

    // Reset held two cycles with a write request pending
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_wready", {31'd0, wready_o}, 32'd0);
      chk("rst_ovalid", {31'd0, ovalid_o}, 32'd0);
      chk("rst_olast",  {31'd0, olast_o},  32'd0);
    end
    rst_n_i  = 1'b1;
    wvalid_i = 1'b0;
    tick();
    chk("post_rst_wready", {31'd0, wready_o}, 32'd1);
    chk("post_rst_level",  {27'd0, level_o},  32'd0);
    chk("post_rst_odata",  {24'd0, odata_o},  32'd0);

    // 3 bits of 0xA0 then 5 bits of 0x98 -> 0xB3
    wr(4'd3, 8'hA0, 1'b0);
    chk("w3_level", {27'd0, level_o}, 32'd3);
    chk("w3_ovalid", {31'd0, ovalid_o}, 32'd0);
    wr(4'd5, 8'h98, 1'b0);
    exp_q.push_back({1'b0, 8'hB3});
    chk("b3_level",  {27'd0, level_o},  32'd8);
    chk("b3_ovalid", {31'd0, ovalid_o}, 32'd1);
    chk("b3_odata",  {24'd0, odata_o},  32'hB3);

    // Fill to 16 while stalled; output must stay put
    wr(4'd8, 8'hFF, 1'b0);
    exp_q.push_back({1'b0, 8'hFF});
    chk("l16_level",  {27'd0, level_o},  32'd16);
    chk("l16_wready", {31'd0, wready_o}, 32'd0);
    chk("l16_odata_stable", {24'd0, odata_o}, 32'hB3);
    tick();
    chk("stall_odata", {24'd0, odata_o}, 32'hB3);
    chk("stall_ovalid", {31'd0, ovalid_o}, 32'd1);
    oready_i = 1'b1;
    tick();
    chk("drain1_level", {27'd0, level_o}, 32'd8);
    chk("drain1_odata", {24'd0, odata_o}, 32'hFF);
    tick();
    chk("drain2_level",  {27'd0, level_o},  32'd0);
    chk("drain2_ovalid", {31'd0, ovalid_o}, 32'd0);

    // Partial word then separate flush
    oready_i = 1'b0;
    wr(4'd3, 8'hE0, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.push_back({1'b1, 8'hE0});
    chk("fl_ovalid", {31'd0, ovalid_o}, 32'd1);
    chk("fl_odata",  {24'd0, odata_o},  32'hE0);
    chk("fl_olast",  {31'd0, olast_o},  32'd1);
    chk("fl_wready", {31'd0, wready_o}, 32'd0);
    oready_i = 1'b1;
    tick();
    oready_i = 1'b0;
    chk("fl_done_level",  {27'd0, level_o},  32'd0);
    chk("fl_done_wready", {31'd0, wready_o}, 32'd1);

    // Flush on empty buffer: no output, nothing pending afterwards
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_empty_ovalid", {31'd0, ovalid_o}, 32'd0);
    chk("fl_empty_wready", {31'd0, wready_o}, 32'd1);

    // Write and flush in the same cycle: field is part of the flush
    wr(4'd5, 8'hF8, 1'b1);
    exp_q.push_back({1'b1, 8'hF8});
    chk("wfl_level", {27'd0, level_o}, 32'd5);
    chk("wfl_olast", {31'd0, olast_o}, 32'd1);
    chk("wfl_odata", {24'd0, odata_o}, 32'hF8);
    oready_i = 1'b1;
    tick();
    oready_i = 1'b0;
    chk("wfl_done_level", {27'd0, level_o}, 32'd0);

    // Width-0 write changes nothing
    wr(4'd0, 8'hFF, 1'b0);
    chk("w0_level",  {27'd0, level_o},  32'd0);
    chk("w0_odata",  {24'd0, odata_o},  32'd0);
    chk("w0_ovalid", {31'd0, ovalid_o}, 32'd0);

    // Simultaneous emit and write at level 8
    wr(4'd8, 8'h3C, 1'b0);
    exp_q.push_back({1'b0, 8'h3C});
    oready_i = 1'b1;
    wr(4'd4, 8'h50, 1'b0);
    oready_i = 1'b0;
    chk("sim_level",  {27'd0, level_o},  32'd4);
    chk("sim_odata",  {24'd0, odata_o},  32'h50);
    chk("sim_ovalid", {31'd0, ovalid_o}, 32'd0);
    wr(4'd4, 8'h90, 1'b0);
    exp_q.push_back({1'b0, 8'h59});
    chk("sim2_odata", {24'd0, odata_o}, 32'h59);
    oready_i = 1'b1;
    tick();
    oready_i = 1'b0;
    chk("sim2_level", {27'd0, level_o}, 32'd0);

    // Oversized width clamps to 8, then clock enable low freezes everything
    wr(4'd15, 8'hC3, 1'b0);
    exp_q.push_back({1'b0, 8'hC3});
    chk("clamp_level", {27'd0, level_o}, 32'd8);
    chk("clamp_odata", {24'd0, odata_o}, 32'hC3);
    cke_i    = 1'b0;
    wvalid_i = 1'b1;
    wwidth_i = 4'd4;
    wdata_i  = 8'hFF;
    flush_i  = 1'b1;
    oready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cke_level",  {27'd0, level_o},  32'd8);
      chk("cke_wready", {31'd0, wready_o}, 32'd0);
      chk("cke_ovalid", {31'd0, ovalid_o}, 32'd0);
      chk("cke_odata",  {24'd0, odata_o},  32'hC3);
    end
    cke_i    = 1'b1;
    wvalid_i = 1'b0;
    flush_i  = 1'b0;
    tick();
    oready_i = 1'b0;
    chk("cke_drain_level", {27'd0, level_o}, 32'd0);

    // Reset mid-operation discards buffered bits and the pending flush
    wr(4'd5, 8'hFF, 1'b1);
    chk("mid_level", {27'd0, level_o}, 32'd5);
    rst_n_i = 1'b0;
    tick();
    chk("mid_rst_ovalid", {31'd0, ovalid_o}, 32'd0);
    rst_n_i = 1'b1;
    tick();
    chk("mid_post_level",  {27'd0, level_o},  32'd0);
    chk("mid_post_odata",  {24'd0, odata_o},  32'd0);
    chk("mid_post_ovalid", {31'd0, ovalid_o}, 32'd0);
    chk("mid_post_wready", {31'd0, wready_o}, 32'd1);

    tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
